// File: rtl/virtual_register_bank.sv
// JTAG source/probe control/status bank: synchronises a toggle-qualified command word,
// writes control registers or samples live probes, and returns an acknowledged status word.
module virtual_register_bank #(
  parameter int unsigned NUM_REGS    = 4,
  parameter int unsigned ADDR_WIDTH  = 2,
  parameter int unsigned DATA_WIDTH  = 32,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter int unsigned SYNC_STAGES = 2,
  localparam int unsigned CW = 2 + ADDR_WIDTH + DATA_WIDTH,
  localparam int unsigned SW = 10 + DATA_WIDTH
) (
  input  logic                           rx_clk,
  input  logic                           rx_reset,
  input  logic [CW-1:0]                  rx_cmd,
  input  logic [NUM_REGS*DATA_WIDTH-1:0] rx_probe_data,
  output logic [SW-1:0]                  tx_status,
  output logic [NUM_REGS*DATA_WIDTH-1:0] tx_regs,
  output logic [NUM_REGS-1:0]            tx_update
);

  localparam int unsigned CNT_W = $clog2(SYNC_STAGES + 1) + 1;

  localparam logic [2:0] S_PRIME   = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_SETTLE  = 3'd2;
  localparam logic [2:0] S_EXECUTE = 3'd3;
  localparam logic [2:0] S_ACK     = 3'd4;

  logic [SYNC_STAGES-1:0][CW-1:0] sync_q;
  logic [CW-1:0]                  cmd_s;
  logic                           cmd_tog_s;

  logic [2:0]                     state_q, state_d;
  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           last_tog_q, last_tog_d;
  logic [CW-1:0]                  snap_q, snap_d;
  logic [NUM_REGS*DATA_WIDTH-1:0] regs_q, regs_d;
  logic [NUM_REGS-1:0]            upd_q, upd_d;
  logic [DATA_WIDTH-1:0]          rb_q, rb_d;
  logic                           err_q, err_d;
  logic [DATA_WIDTH-1:0]          sts_rb_q, sts_rb_d;
  logic                           sts_err_q, sts_err_d;
  logic                           ack_q, ack_d;
  logic [7:0]                     seq_q, seq_d;

  logic                           snap_wr;
  logic [ADDR_WIDTH-1:0]          snap_addr;
  logic [DATA_WIDTH-1:0]          snap_data;
  logic                           addr_ok;
  logic [DATA_WIDTH-1:0]          probe_sel;

  // Whole command bus is synchronised; skew between bits is resolved by SETTLE.
  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], rx_cmd};
    end
  end

  assign cmd_s     = sync_q[SYNC_STAGES-1];
  assign cmd_tog_s = cmd_s[CW-1];

  assign snap_wr   = snap_q[CW-2];
  assign snap_addr = snap_q[DATA_WIDTH +: ADDR_WIDTH];
  assign snap_data = snap_q[DATA_WIDTH-1:0];
  assign addr_ok   = {1'b0, snap_addr} < (ADDR_WIDTH + 1)'(NUM_REGS);

  always_comb begin
    probe_sel = '0;
    for (int unsigned i = 0; i < NUM_REGS; i++) begin
      if (ADDR_WIDTH'(i) == snap_addr) begin
        probe_sel = rx_probe_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  // Status fields are published together in ACK so ack_toggle never leads its data.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    last_tog_d = last_tog_q;
    snap_d     = snap_q;
    regs_d     = regs_q;
    upd_d      = '0;
    rb_d       = rb_q;
    err_d      = err_q;
    sts_rb_d   = sts_rb_q;
    sts_err_d  = sts_err_q;
    ack_d      = ack_q;
    seq_d      = seq_q;

    case (state_q)
      S_PRIME: begin
        if (cnt_q == CNT_W'(SYNC_STAGES)) begin
          last_tog_d = cmd_tog_s;
          state_d    = S_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_IDLE: begin
        if (cmd_tog_s != last_tog_q) begin
          snap_d     = cmd_s;
          last_tog_d = cmd_tog_s;
          state_d    = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (cmd_s == snap_q) begin
          state_d = S_EXECUTE;
        end else begin
          snap_d     = cmd_s;
          last_tog_d = cmd_tog_s;
        end
      end
      S_EXECUTE: begin
        state_d = S_ACK;
        if (addr_ok) begin
          err_d = 1'b0;
          if (snap_wr) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
              if (ADDR_WIDTH'(i) == snap_addr) begin
                regs_d[i*DATA_WIDTH +: DATA_WIDTH] = snap_data;
                upd_d[i] = 1'b1;
              end
            end
            rb_d = snap_data;
          end else begin
            rb_d = probe_sel;
          end
        end else begin
          err_d = 1'b1;
          rb_d  = '0;
        end
      end
      S_ACK: begin
        ack_d     = ~ack_q;
        seq_d     = seq_q + 8'd1;
        sts_rb_d  = rb_q;
        sts_err_d = err_q;
        state_d   = S_IDLE;
      end
      default: begin
        state_d = S_PRIME;
      end
    endcase
  end

  always_ff @(posedge rx_clk) begin
    if (rx_reset) begin
      state_q    <= S_PRIME;
      cnt_q      <= '0;
      last_tog_q <= 1'b0;
      snap_q     <= '0;
      regs_q     <= {NUM_REGS{RESET_VALUE}};
      upd_q      <= '0;
      rb_q       <= '0;
      err_q      <= 1'b0;
      sts_rb_q   <= '0;
      sts_err_q  <= 1'b0;
      ack_q      <= 1'b0;
      seq_q      <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      last_tog_q <= last_tog_d;
      snap_q     <= snap_d;
      regs_q     <= regs_d;
      upd_q      <= upd_d;
      rb_q       <= rb_d;
      err_q      <= err_d;
      sts_rb_q   <= sts_rb_d;
      sts_err_q  <= sts_err_d;
      ack_q      <= ack_d;
      seq_q      <= seq_d;
    end
  end

  assign tx_status = {ack_q, sts_err_q, seq_q, sts_rb_q};
  assign tx_regs   = regs_q;
  assign tx_update = upd_q;

endmodule
